// File: rtl/mem_access_stage.sv
// MiniMIPS32 memory-access stage: LB/LW/SB/SW over a req/ack data bus,
// stalling until completion, with MEM/WB payload and forwarding outputs.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [7:0]  mem_aluop_i,
    input  logic [4:0]  mem_wa_i,
    input  logic        mem_wreg_i,
    input  logic        mem_mreg_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_wd_i,
    input  logic [31:0] mem_din_i,
    input  logic [63:0] mem_hilo_i,
    input  logic        stall_hold_i,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  mem_wa_o,
    output logic        mem_wreg_o,
    output logic        mem_mreg_o,
    output logic        mem_whilo_o,
    output logic [63:0] mem_hilo_o,
    output logic [31:0] mem_dreg_o,
    output logic        mem2id_wreg,
    output logic [4:0]  mem2id_wa,
    output logic [31:0] mem2id_wd,
    output logic        mem2exe_whilo,
    output logic [63:0] mem2exe_hilo,
    output logic        stallreq_mem,
    output logic        mem_err_o
);

    localparam logic [7:0] OP_LB = 8'h90;
    localparam logic [7:0] OP_LW = 8'h92;
    localparam logic [7:0] OP_SB = 8'h98;
    localparam logic [7:0] OP_SW = 8'h9A;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rbuf;
    logic             err_q;

    logic       is_lb, is_lw, is_sb, is_sw, is_load, is_mem;
    logic [1:0] lane;
    logic       misalign, start, req, done;
    logic [7:0] lb_byte;
    logic [31:0] load_val;

    assign is_lb    = (mem_aluop_i == OP_LB);
    assign is_lw    = (mem_aluop_i == OP_LW);
    assign is_sb    = (mem_aluop_i == OP_SB);
    assign is_sw    = (mem_aluop_i == OP_SW);
    assign is_load  = is_lb | is_lw;
    assign is_mem   = is_load | is_sb | is_sw;
    assign lane     = mem_wd_i[1:0];
    assign misalign = (is_lw | is_sw) & (lane != 2'b00);
    assign start    = (state == IDLE) & is_mem & ~misalign;
    assign req      = start | (state == WAIT);
    assign done     = (state == DONE);

    always_comb begin
        lb_byte = rbuf[7:0];
        unique case (lane)
            2'd0: lb_byte = rbuf[7:0];
            2'd1: lb_byte = rbuf[15:8];
            2'd2: lb_byte = rbuf[23:16];
            2'd3: lb_byte = rbuf[31:24];
        endcase
    end

    assign load_val = is_lb ? {{24{lb_byte[7]}}, lb_byte} : rbuf;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state <= IDLE;
            cnt   <= '0;
            rbuf  <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (dm_ack) begin
                            rbuf  <= is_load ? dm_rdata : 32'h0;
                            err_q <= 1'b0;
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_W'(1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dm_ack) begin
                        rbuf  <= is_load ? dm_rdata : 32'h0;
                        err_q <= 1'b0;
                        state <= DONE;
                    end else if (cnt == TMO) begin
                        rbuf  <= 32'h0;
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!stall_hold_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dm_req        = 1'b0;
        dm_we         = 4'h0;
        dm_addr       = 32'h0;
        dm_wdata      = 32'h0;
        mem_wa_o      = 5'h0;
        mem_wreg_o    = 1'b0;
        mem_mreg_o    = 1'b0;
        mem_whilo_o   = 1'b0;
        mem_hilo_o    = 64'h0;
        mem_dreg_o    = 32'h0;
        mem_err_o     = 1'b0;
        stallreq_mem  = 1'b0;
        mem2exe_whilo = 1'b0;
        mem2exe_hilo  = 64'h0;
        if (!cpu_rst) begin
            dm_req = req;
            if (req) begin
                dm_addr = {mem_wd_i[31:2], 2'b00};
                if (is_sb) begin
                    dm_we    = 4'(4'b0001 << lane);
                    dm_wdata = {4{mem_din_i[7:0]}};
                end else if (is_sw) begin
                    dm_we    = 4'hF;
                    dm_wdata = mem_din_i;
                end
            end
            mem_wa_o      = mem_wa_i;
            mem_wreg_o    = mem_wreg_i;
            mem_mreg_o    = mem_mreg_i;
            mem_whilo_o   = mem_whilo_i;
            mem_hilo_o    = mem_hilo_i;
            mem_dreg_o    = mem_wd_i;
            stallreq_mem  = req;
            mem2exe_whilo = mem_whilo_i;
            mem2exe_hilo  = mem_hilo_i;
            if (state == IDLE && misalign) begin
                mem_wreg_o = 1'b0;
                mem_dreg_o = 32'h0;
                mem_err_o  = 1'b1;
            end
            if (done) begin
                mem_dreg_o = load_val;
                mem_err_o  = err_q;
                if (err_q) mem_wreg_o = 1'b0;
            end
        end
    end

    // Decode must never forward a load result that is still in flight.
    assign mem2id_wreg = mem_wreg_o & ~stallreq_mem;
    assign mem2id_wa   = mem_wa_o;
    assign mem2id_wd   = mem_dreg_o;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage against a transaction-level model.
module tb_mem_access_stage;

    localparam int TMO = 4;
    localparam logic [7:0] OP_LB = 8'h90;
    localparam logic [7:0] OP_LW = 8'h92;
    localparam logic [7:0] OP_SB = 8'h98;
    localparam logic [7:0] OP_SW = 8'h9A;
    localparam logic [7:0] OP_ADDIU = 8'h19;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic [7:0]  mem_aluop_i;
    logic [4:0]  mem_wa_i;
    logic        mem_wreg_i, mem_mreg_i, mem_whilo_i;
    logic [31:0] mem_wd_i, mem_din_i;
    logic [63:0] mem_hilo_i;
    logic        stall_hold_i;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [4:0]  mem_wa_o;
    logic        mem_wreg_o, mem_mreg_o, mem_whilo_o;
    logic [63:0] mem_hilo_o;
    logic [31:0] mem_dreg_o;
    logic        mem2id_wreg;
    logic [4:0]  mem2id_wa;
    logic [31:0] mem2id_wd;
    logic        mem2exe_whilo;
    logic [63:0] mem2exe_hilo;
    logic        stallreq_mem, mem_err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .cpu_clk_50M(clk), .cpu_rst(cpu_rst),
        .mem_aluop_i(mem_aluop_i), .mem_wa_i(mem_wa_i),
        .mem_wreg_i(mem_wreg_i), .mem_mreg_i(mem_mreg_i),
        .mem_whilo_i(mem_whilo_i), .mem_wd_i(mem_wd_i),
        .mem_din_i(mem_din_i), .mem_hilo_i(mem_hilo_i),
        .stall_hold_i(stall_hold_i),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_wa_o(mem_wa_o), .mem_wreg_o(mem_wreg_o),
        .mem_mreg_o(mem_mreg_o), .mem_whilo_o(mem_whilo_o),
        .mem_hilo_o(mem_hilo_o), .mem_dreg_o(mem_dreg_o),
        .mem2id_wreg(mem2id_wreg), .mem2id_wa(mem2id_wa),
        .mem2id_wd(mem2id_wd), .mem2exe_whilo(mem2exe_whilo),
        .mem2exe_hilo(mem2exe_hilo), .stallreq_mem(stallreq_mem),
        .mem_err_o(mem_err_o)
    );

    function automatic bit is_memop(input logic [7:0] op);
        return op == OP_LB || op == OP_LW || op == OP_SB || op == OP_SW;
    endfunction

    function automatic bit is_loadop(input logic [7:0] op);
        return op == OP_LB || op == OP_LW;
    endfunction

    // Reference: what the register file should receive for a load.
    function automatic logic [31:0] model_load(input logic [7:0] op,
                                               input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        if (op == OP_LW) return rd;
        sh = rd >> (8 * addr[1:0]);
        return 32'($signed(sh[7:0]));
    endfunction

    function automatic logic [3:0] model_we(input logic [7:0] op,
                                            input logic [31:0] addr);
        if (op == OP_SW) return 4'hF;
        if (op == OP_SB) return 4'(1 << addr[1:0]);
        return 4'h0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op,
                                                input logic [31:0] din);
        if (op == OP_SB) return {din[7:0], din[7:0], din[7:0], din[7:0]};
        return din;
    endfunction

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] din);
        mem_aluop_i = op;
        mem_wd_i    = addr;
        mem_din_i   = din;
        mem_wa_i    = 5'($urandom);
        mem_wreg_i  = !(op == OP_SB || op == OP_SW);
        mem_mreg_i  = is_loadop(op);
        mem_whilo_i = 1'($urandom);
        mem_hilo_i  = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        stall_hold_i = 1'b0;
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        set_op(OP_LW, 32'h40, 32'h5);
        mem_wreg_i = 1'b1;
        mem_whilo_i = 1'b1;
        mem_hilo_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, mem_wa_o, mem_wreg_o,
             mem_mreg_o, mem_whilo_o, mem_hilo_o, mem_dreg_o, mem2id_wreg,
             mem2id_wa, mem2id_wd, mem2exe_whilo, mem2exe_hilo,
             stallreq_mem, mem_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b dreg=%h hilo=%h stall=%b",
                     dm_req, mem_dreg_o, mem2exe_hilo, stallreq_mem);
        end
        @(posedge clk);
        #1;
        cpu_rst = 1'b0;
        dm_ack = 1'b0;
        set_op(OP_ADDIU, 32'h0, 32'h0);
    endtask

    // One complete memory transaction: ack_at is the cycle index of the
    // ack counted from the request cycle (-1 = never), hold = DONE stalls.
    task automatic test_mem_op(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] din, input logic [31:0] rd,
                               input int ack_at, input int hold,
                               input string tag);
        int nreq;
        bit exp_err;
        logic [31:0] exp_d;
        bit exp_wreg;
        exp_err = !(ack_at >= 0 && ack_at <= TMO);
        nreq = exp_err ? TMO + 1 : ack_at + 1;
        exp_d = exp_err ? 32'h0 : model_load(op, addr, rd);
        set_op(op, addr, din);
        stall_hold_i = 1'b0;
        exp_wreg = mem_wreg_i && !exp_err;
        for (int i = 0; i < nreq; i++) begin
            dm_ack = (i == ack_at);
            dm_rdata = (i == ack_at) ? rd : $urandom;
            @(negedge clk);
            checks++;
            if ({dm_req, stallreq_mem, mem2id_wreg, mem_err_o} !== 4'b1100) begin
                errors++;
                $display("FAIL %s req_phase[%0d]: req/stall/fwd/err=%b%b%b%b need 1100",
                         tag, i, dm_req, stallreq_mem, mem2id_wreg, mem_err_o);
            end
            checks++;
            if (dm_addr !== {addr[31:2], 2'b00} || dm_we !== model_we(op, addr)) begin
                errors++;
                $display("FAIL %s bus_addr[%0d]: addr=%h we=%b need %h %b", tag, i,
                         dm_addr, dm_we, {addr[31:2], 2'b00}, model_we(op, addr));
            end
            if (!is_loadop(op)) begin
                checks++;
                if (dm_wdata !== model_wdata(op, din)) begin
                    errors++;
                    $display("FAIL %s wdata[%0d]: got %h need %h", tag, i,
                             dm_wdata, model_wdata(op, din));
                end
            end
            @(posedge clk);
            #1;
        end
        for (int h = 0; h <= hold; h++) begin
            stall_hold_i = (h < hold);
            dm_ack = 1'b1;
            dm_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({dm_req, stallreq_mem, mem_err_o, mem_wreg_o, mem2id_wreg} !==
                {1'b0, 1'b0, exp_err, exp_wreg, exp_wreg}) begin
                errors++;
                $display("FAIL %s done[%0d]: req/stall/err/wreg/fwd=%b%b%b%b%b need 00%b%b%b",
                         tag, h, dm_req, stallreq_mem, mem_err_o, mem_wreg_o,
                         mem2id_wreg, exp_err, exp_wreg, exp_wreg);
            end
            if (is_loadop(op) || exp_err) begin
                checks++;
                if (mem_dreg_o !== exp_d || mem2id_wd !== exp_d) begin
                    errors++;
                    $display("FAIL %s done_data[%0d]: dreg=%h fwd=%h need %h",
                             tag, h, mem_dreg_o, mem2id_wd, exp_d);
                end
            end
            @(posedge clk);
            #1;
        end
        dm_ack = 1'b0;
        stall_hold_i = 1'b0;
        set_op(OP_ADDIU, 32'h0, 32'h0);
    endtask

    task automatic test_misaligned(input logic [7:0] op, input logic [31:0] addr);
        set_op(op, addr, $urandom);
        dm_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({dm_req, mem_err_o, mem_wreg_o, stallreq_mem, mem2id_wreg} !== 5'b01000 ||
            mem_dreg_o !== 32'h0) begin
            errors++;
            $display("FAIL misaligned %h@%h: req/err/wreg/stall/fwd=%b%b%b%b%b dreg=%h need 01000 0",
                     op, addr, dm_req, mem_err_o, mem_wreg_o, stallreq_mem,
                     mem2id_wreg, mem_dreg_o);
        end
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        set_op(OP_ADDIU, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (dm_req !== 1'b0 || stallreq_mem !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_after: req=%b stall=%b need 0 0",
                     dm_req, stallreq_mem);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough(input logic [7:0] op, input logic [31:0] wd,
                                    input logic wl, input logic [63:0] hl);
        set_op(op, wd, $urandom);
        mem_whilo_i = wl;
        mem_hilo_i = hl;
        @(negedge clk);
        checks++;
        if ({mem_wa_o, mem_wreg_o, mem_mreg_o, mem_whilo_o, mem_hilo_o,
             mem_dreg_o, mem2id_wa, mem2id_wreg, mem2id_wd, mem2exe_whilo,
             mem2exe_hilo} !==
            {mem_wa_i, mem_wreg_i, mem_mreg_i, wl, hl, wd, mem_wa_i,
             mem_wreg_i, wd, wl, hl}) begin
            errors++;
            $display("FAIL passthrough %h: dreg=%h fwd=%h hilo=%h exe=%h need %h %h",
                     op, mem_dreg_o, mem2id_wd, mem_hilo_o, mem2exe_hilo, wd, hl);
        end
        checks++;
        if ({dm_req, stallreq_mem, mem_err_o} !== 3'b000) begin
            errors++;
            $display("FAIL passthrough_bus %h: req/stall/err=%b%b%b need 000",
                     op, dm_req, stallreq_mem, mem_err_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_access();
        set_op(OP_LW, 32'h100, 32'h0);
        dm_ack = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        cpu_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dm_req, stallreq_mem, mem_wreg_o, mem_wa_o, mem_dreg_o,
             mem2id_wd, mem2exe_hilo, mem_hilo_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid: req=%b stall=%b wreg=%b dreg=%h hilo=%h need 0",
                     dm_req, stallreq_mem, mem_wreg_o, mem_dreg_o, mem2exe_hilo);
        end
        @(posedge clk);
        #1;
        cpu_rst = 1'b0;
        test_mem_op(OP_LW, 32'h104, 32'h0, 32'hCAFE_F00D, 1, 0, "lw_after_rst");
    endtask

    task automatic test_random(input int n);
        logic [7:0] op;
        logic [31:0] addr;
        int sel;
        for (int k = 0; k < n; k++) begin
            sel = int'($urandom_range(0, 4));
            op = (sel == 0) ? OP_LB : (sel == 1) ? OP_LW :
                 (sel == 2) ? OP_SB : (sel == 3) ? OP_SW : 8'($urandom);
            if (sel == 4 && is_memop(op)) op = OP_ADDIU;
            addr = $urandom;
            if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0)
                addr[1:0] = 2'b00;
            if (!is_memop(op))
                test_passthrough(op, addr, 1'($urandom), {$urandom, $urandom});
            else if ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00)
                test_misaligned(op, addr);
            else
                test_mem_op(op, addr, $urandom, $urandom,
                            int'($urandom_range(0, 6)) - 1,
                            int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_mem_op(OP_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, 0, "lw_wait");
        test_mem_op(OP_LB, 32'h13, 32'h0, 32'h80FF_0000, 0, 0, "lb_zero_wait");
        test_mem_op(OP_SB, 32'h21, 32'h0000_00AB, 32'h0, 1, 0, "sb_lane1");
        test_mem_op(OP_SW, 32'h24, 32'h1234_5678, 32'h0, 0, 0, "sw");
        test_misaligned(OP_SW, 32'h06);
        test_misaligned(OP_LW, 32'h03);
        test_mem_op(OP_LW, 32'h30, 32'h0, 32'h5555_AAAA, -1, 0, "lw_timeout");
        test_mem_op(OP_LW, 32'h34, 32'h0, 32'h7777_1111, TMO, 0, "lw_last_ack");
        test_reset_mid_access();
        test_passthrough(OP_ADDIU, 32'h1234, 1'b1, 64'h0000_0001_0000_0002);
        test_mem_op(OP_LW, 32'h40, 32'h0, 32'h0BAD_CAFE, 1, 2, "lw_hold");
        test_mem_op(OP_LB, 32'h41, 32'h0, 32'h1234_7F56, 0, 1, "lb_hold");
        test_random(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
